// File: rtl/proc_bus_pkg.sv
// Shared processor-bus types: arbiter state encoding, bus width default,
// requester index map and a constant-foldable clog2.
package proc_bus_pkg;

   localparam int unsigned BUS_DATA_WIDTH = 16;

   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_PC  = 1;
   localparam int unsigned REQ_RAM = 2;
   localparam int unsigned REQ_ROM = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } bus_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first set req bit strictly after rr_ptr, wrapping,
// so the requester at rr_ptr itself has lowest priority.
module rr_priority_pick
   import proc_bus_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IW = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IW-1:0]      winner_idx,
   output logic               any_req
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      idx        = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((32'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found       = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner arbitration for the shared data bus with hold-limit release.
// Define DATA_BUS_TURNAROUND_EN to insert a one-cycle TURN gap after every release.
module data_bus_arbiter
   import proc_bus_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
   parameter int unsigned MAX_HOLD   = 8,
   localparam int unsigned IW = clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [IW-1:0]                 owner_id,
   output logic [DATA_WIDTH-1:0]         bus_data,
   output logic                          bus_valid,
   output logic                          timeout
);

   localparam int unsigned HW = clog2(MAX_HOLD + 1);

   bus_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_d;
   logic [IW-1:0]      owner_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic               timeout_d;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IW-1:0]      pick_idx;
   logic               any_req;
   logic               owner_req;
   logic               owner_last;
   logic               arbitrate;

   rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req        (req),
      .rr_ptr     (rr_ptr_q),
      .winner     (pick_onehot),
      .winner_idx (pick_idx),
      .any_req    (any_req)
   );

   assign owner_req  = req[owner_id];
   assign owner_last = last[owner_id];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant    <= '0;
         owner_id <= '0;
         hold_q   <= '0;
         rr_ptr_q <= IW'(NUM_REQ - 1);
         timeout  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant    <= grant_d;
         owner_id <= owner_d;
         hold_q   <= hold_d;
         rr_ptr_q <= rr_ptr_d;
         timeout  <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant;
      owner_d   = owner_id;
      hold_d    = hold_q;
      rr_ptr_d  = rr_ptr_q;
      timeout_d = 1'b0;
      arbitrate = 1'b0;
      case (state_q)
         IDLE: arbitrate = 1'b1;
         BUSY: begin
            // last or abandon take precedence, so timeout only for a live owner hitting the limit
            if (owner_last || !owner_req || hold_q == HW'(MAX_HOLD)) begin
               timeout_d = owner_req && !owner_last;
`ifdef DATA_BUS_TURNAROUND_EN
               state_d = TURN;
               grant_d = '0;
               hold_d  = '0;
`else
               arbitrate = 1'b1;
`endif
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
`ifdef DATA_BUS_TURNAROUND_EN
         TURN: arbitrate = 1'b1;
`endif
         default: begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
         end
      endcase

      // rr_ptr tracks the current owner, so a releasing owner re-competes last
      if (arbitrate) begin
         if (any_req) begin
            state_d  = BUSY;
            grant_d  = pick_onehot;
            owner_d  = pick_idx;
            rr_ptr_d = pick_idx;
            hold_d   = HW'(1);
         end else begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
         end
      end
   end

   always_comb begin
      bus_data = '0;
      if (state_q == BUSY) bus_data = wr_data[32'(owner_id)*DATA_WIDTH +: DATA_WIDTH];
   end

   assign bus_valid = (state_q == BUSY) && owner_req;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized bench for data_bus_arbiter against a per-cycle ownership model.
module tb_data_bus_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int MH = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req;
   logic [NR-1:0]     last;
   logic [NR*DW-1:0]  wr_data;
   logic [NR-1:0]     grant;
   logic [1:0]        owner_id;
   logic [DW-1:0]     bus_data;
   logic              bus_valid;
   logic              timeout;

   int errors = 0;
   int checks = 0;

   // model: owner index (-1 = no owner), beats held, last winner, timeout pending
   int m_owner;
   int m_hold;
   int m_ptr;
   bit m_to;
   logic [NR-1:0] held_req;

   data_bus_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .last      (last),
      .wr_data   (wr_data),
      .grant     (grant),
      .owner_id  (owner_id),
      .bus_data  (bus_data),
      .bus_valid (bus_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_hold  = 0;
      m_ptr   = NR - 1;
      m_to    = 1'b0;
   endtask

   function automatic int pick();
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (m_ptr + k) % NR;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w;
      bit to;
      to = 1'b0;
      if (m_owner < 0) begin
         w = pick();
         if (w >= 0) begin m_owner = w; m_hold = 1; m_ptr = w; end
      end else if (last[m_owner] || !req[m_owner] || m_hold == MH) begin
         to = req[m_owner] && !last[m_owner];
`ifdef DATA_BUS_TURNAROUND_EN
         m_owner = -1;
         m_hold  = 0;
`else
         w = pick();
         if (w >= 0) begin m_owner = w; m_hold = 1; m_ptr = w; end
         else begin m_owner = -1; m_hold = 0; end
`endif
      end else begin
         m_hold++;
      end
      m_to = to;
   endtask

   // entered at posedge+1 with inputs driven; returns at the next posedge+1
   task automatic cycle();
      logic [NR-1:0] eg;
      logic [DW-1:0] ed;
      @(negedge clk);
      eg = '0;
      ed = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         ed = wr_data[m_owner*DW +: DW];
         chk("owner_id", 32'(owner_id), 32'(m_owner));
      end
      chk("grant", 32'(grant), 32'(eg));
      chk("bus_data", 32'(bus_data), 32'(ed));
      chk("bus_valid", 32'(bus_valid), 32'((m_owner >= 0) && req[m_owner]));
      chk("timeout", 32'(timeout), 32'(m_to));
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic gen(input int mode);
      wr_data = {$urandom, $urandom};
      case (mode)
         0: begin
            req  = NR'($urandom_range(0, 15));
            last = ($urandom_range(0, 7) == 0) ? NR'($urandom) : '0;
         end
         1: begin req = 4'b0100; last = '0; end
         2: begin req = 4'b1111; last = 4'b1111; end
         3: begin req = NR'($urandom); last = NR'($urandom); end
         default: begin
            if ($urandom_range(0, 11) == 0) held_req = NR'($urandom);
            req  = held_req;
            last = ($urandom_range(0, 9) == 0) ? NR'($urandom) : '0;
         end
      endcase
   endtask

   initial begin
      reset    = 1'b1;
      req      = '0;
      last     = '0;
      wr_data  = '0;
      held_req = 4'b1010;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_owner", 32'(owner_id), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_valid", 32'(bus_valid), 32'd0);
      chk("rst_data", 32'(bus_data), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single requester: three beats, last on the third
      req = 4'b0001;
      wr_data = 64'h0000_0000_0000_1234;
      cycle();
      chk("s1_grant", 32'(grant), 32'h1);
      cycle();
      cycle();
      last = 4'b0001;
      cycle();
      req = '0;
      last = '0;
      repeat (2) cycle();

      for (int mode = 0; mode < 5; mode++) begin
         for (int n = 0; n < 150; n++) begin
            gen(mode);
            cycle();
         end
      end

      // asynchronous reset while requester 2 owns the bus
      req = '0;
      last = '0;
      repeat (2) cycle();
      req = 4'b0100;
      repeat (3) cycle();
      chk("pre_rst_grant", 32'(grant), 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_valid", 32'(bus_valid), 32'd0);
      chk("arst_data", 32'(bus_data), 32'd0);
      req = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      req = 4'b0101;
      cycle();
      chk("rst_rr_first", 32'(grant), 32'h1);
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
